// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async Ethernet FIFO: issues pops, absorbs the one-cycle
// BRAM latency in a 2-entry prefetch buffer and presents a valid/ready stream with frame lengths.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 9,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  i_clk_rd,
    input  logic                  i_rst_n,
    input  logic                  i_empty,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-2:0] o_tdata,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_frame_done,
    output logic [LEN_WIDTH-1:0]  o_frame_len
);

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    logic                  e0_valid, e1_valid, in_flight;
    logic [DATA_WIDTH-1:0] e0_data, e1_data;
    logic                  e0_valid_n, e1_valid_n;
    logic [DATA_WIDTH-1:0] e0_data_n, e1_data_n;
    logic [LEN_WIDTH-1:0]  beat_cnt, beat_inc;
    logic [1:0]            credit;
    logic                  take, pop;

    // Credit counts every word already owed to the buffer, including the one still in the BRAM.
    assign credit = {1'b0, e0_valid} + {1'b0, e1_valid} + {1'b0, in_flight};
    assign take   = e0_valid && i_tready;
    assign pop    = i_rst_n && !i_empty && ((credit < 2'd2) || take);

    assign o_rd_en  = pop;
    assign o_tvalid = e0_valid;
    assign o_tdata  = e0_data[DATA_WIDTH-2:0];
    assign o_tlast  = e0_data[DATA_WIDTH-1];

    assign beat_inc = (beat_cnt == LEN_MAX) ? LEN_MAX : beat_cnt + LEN_WIDTH'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        e0_valid_n = e0_valid;
        e0_data_n  = e0_data;
        e1_valid_n = e1_valid;
        e1_data_n  = e1_data;
        if (take) begin
            if (e1_valid) begin
                e0_valid_n = 1'b1;
                e0_data_n  = e1_data;
                e1_valid_n = in_flight;
                if (in_flight) e1_data_n = i_rd_data;
            end else begin
                e0_valid_n = in_flight;
                if (in_flight) e0_data_n = i_rd_data;
            end
        end else if (in_flight) begin
            if (!e0_valid) begin
                e0_valid_n = 1'b1;
                e0_data_n  = i_rd_data;
            end else begin
                e1_valid_n = 1'b1;
                e1_data_n  = i_rd_data;
            end
        end
    end

    always_ff @(posedge i_clk_rd or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the data entries are reset too, because the head entry drives o_tdata/o_tlast
            // directly and those must read zero during reset.
            e0_valid     <= 1'b0;
            e1_valid     <= 1'b0;
            e0_data      <= '0;
            e1_data      <= '0;
            in_flight    <= 1'b0;
            beat_cnt     <= '0;
            o_frame_len  <= '0;
            o_frame_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            e0_valid     <= e0_valid_n;
            e1_valid     <= e1_valid_n;
            e0_data      <= e0_data_n;
            e1_data      <= e1_data_n;
            in_flight    <= pop;
            o_frame_done <= take && o_tlast;
            if (take) begin
                if (o_tlast) begin
                    o_frame_len <= beat_inc;
                    beat_cnt    <= '0;
                end else begin
                    beat_cnt    <= beat_inc;
                end
            end
        end
    end

    // A pop may coincide with a take at full credit, but credit itself never passes 2.
    a_credit_max : assert property (@(posedge i_clk_rd) disable iff (!i_rst_n) credit <= 2'd2);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: emulates the pointer generator/BRAM and checks the stream every
// cycle against a queue-based model of popped-but-unsent words, plus literal expectations.
module tb_fifo_rd_stream;

    logic       i_clk_rd = 1'b0;
    logic       i_rst_n, i_empty, i_tready;
    logic [8:0] i_rd_data;
    logic       o_rd_en, o_tlast, o_tvalid, o_frame_done;
    logic [7:0] o_tdata;
    logic [10:0] o_frame_len;

    fifo_rd_stream dut (
        .i_clk_rd     (i_clk_rd),
        .i_rst_n      (i_rst_n),
        .i_empty      (i_empty),
        .o_rd_en      (o_rd_en),
        .i_rd_data    (i_rd_data),
        .o_tdata      (o_tdata),
        .o_tlast      (o_tlast),
        .o_tvalid     (o_tvalid),
        .i_tready     (i_tready),
        .o_frame_done (o_frame_done),
        .o_frame_len  (o_frame_len)
    );

    always #5 i_clk_rd = ~i_clk_rd;

    typedef struct {
        logic [8:0] w;
        int         cyc;
    } ent_t;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] src[$];
    ent_t       q[$];
    logic [8:0] out_log[$];
    logic [8:0] exp_log[$];
    logic [8:0] pend;
    bit         have_pend = 0;
    int         cyc = 0;
    int         cnt = 0;
    int         exp_len = 0;
    bit         exp_done = 0;
    bit         prev_stall = 0;
    logic [8:0] prev_word;
    int         rd_cnt, tv_cnt, done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 2047) ? 2047 : v;
    endfunction

    task automatic clr_stats();
        rd_cnt = 0;
        tv_cnt = 0;
        done_cnt = 0;
        out_log.delete();
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, out_log.size(), exp_log.size());
        if (out_log.size() == exp_log.size())
            foreach (exp_log[k]) check(name, out_log[k], exp_log[k]);
    endtask

    // One clock cycle: drive inputs, compare every DUT output to the model, advance the model.
    task automatic step(input logic rdy);
        logic       exp_tv, exp_take, exp_rd;
        logic [8:0] head;
        @(negedge i_clk_rd);
        i_tready  = rdy;
        i_empty   = (src.size() == 0);
        i_rd_data = have_pend ? pend : 9'h0A5;
        have_pend = 0;
        #1;
        exp_tv   = (q.size() > 0) && (q[0].cyc <= cyc - 2);
        head     = exp_tv ? q[0].w : 9'h000;
        exp_take = exp_tv && rdy;
        exp_rd   = i_rst_n && !i_empty && ((q.size() < 2) || exp_take);

        check("rd_en", o_rd_en, exp_rd);
        check("tvalid", o_tvalid, exp_tv);
        if (exp_tv) begin
            check("tdata", o_tdata, head[7:0]);
            check("tlast", o_tlast, head[8]);
        end
        check("frame_done", o_frame_done, exp_done);
        check("frame_len", o_frame_len, exp_len);
        if (prev_stall && o_tvalid) check("stall_hold", {o_tlast, o_tdata}, prev_word);
        prev_stall = o_tvalid && !rdy;
        prev_word  = {o_tlast, o_tdata};
        if (o_rd_en) rd_cnt++;
        if (o_tvalid) tv_cnt++;
        if (o_frame_done) done_cnt++;

        exp_done = 0;
        if (exp_take) begin
            out_log.push_back({o_tlast, o_tdata});
            void'(q.pop_front());
            if (head[8]) begin
                exp_len  = sat(cnt + 1);
                exp_done = 1;
                cnt      = 0;
            end else begin
                cnt = sat(cnt + 1);
            end
        end
        if (exp_rd) begin
            pend      = src.pop_front();
            have_pend = 1;
            q.push_back('{w: pend, cyc: cyc});
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge i_clk_rd);
        i_rst_n = 1'b0;
        #1;
        check("rst_tvalid", o_tvalid, 1'b0);
        check("rst_tdata", o_tdata, 8'h00);
        check("rst_tlast", o_tlast, 1'b0);
        check("rst_done", o_frame_done, 1'b0);
        check("rst_len", o_frame_len, 11'd0);
        check("rst_rd_en", o_rd_en, 1'b0);
        q.delete();
        src.delete();
        have_pend  = 0;
        cnt        = 0;
        exp_len    = 0;
        exp_done   = 0;
        prev_stall = 0;
        step(1'b1);
        step(1'b1);
        @(negedge i_clk_rd);
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_empty   = 1'b1;
        i_tready  = 1'b0;
        i_rd_data = '0;
        clr_stats();
        do_reset();

        // Basic 4-word frame at full throughput.
        clr_stats();
        src = {9'h011, 9'h022, 9'h033, 9'h1FF};
        repeat (8) step(1'b1);
        check("t1_pops", rd_cnt, 4);
        check("t1_valid_beats", tv_cnt, 4);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_frame_len", o_frame_len, 11'd4);
        exp_log = {9'h011, 9'h022, 9'h033, 9'h1FF};
        check_log("t1_seq");

        // Same frame with downstream stalled, then released.
        clr_stats();
        src = {9'h011, 9'h022, 9'h033, 9'h1FF};
        repeat (6) step(1'b0);
        check("t2_pops_stalled", rd_cnt, 2);
        check("t2_tvalid", o_tvalid, 1'b1);
        check("t2_tdata", o_tdata, 8'h11);
        repeat (8) step(1'b1);
        check("t2_frame_len", o_frame_len, 11'd4);
        check_log("t2_seq");

        // 16-word frame with ready toggling every cycle.
        clr_stats();
        exp_log.delete();
        for (int k = 0; k < 16; k++) begin
            src.push_back({(k == 15), 8'(8'h40 + k)});
            exp_log.push_back({(k == 15), 8'(8'h40 + k)});
        end
        for (int i = 0; i < 40; i++) step(i % 2 == 0);
        check("t3_frame_len", o_frame_len, 11'd16);
        check_log("t3_seq");

        // FIFO runs dry after 3 of 6 words and refills 5 cycles later.
        clr_stats();
        src = {9'h061, 9'h062, 9'h063};
        repeat (10) step(1'b1);
        check("t4_gap_tvalid", o_tvalid, 1'b0);
        src = {9'h064, 9'h065, 9'h166};
        repeat (8) step(1'b1);
        check("t4_valid_beats", tv_cnt, 6);
        check("t4_frame_len", o_frame_len, 11'd6);
        exp_log = {9'h061, 9'h062, 9'h063, 9'h064, 9'h065, 9'h166};
        check_log("t4_seq");

        // Oversized frame saturates the length, next one-word frame reports 1.
        clr_stats();
        for (int k = 0; k < 2100; k++) src.push_back({(k == 2099), 8'(k)});
        repeat (2106) step(1'b1);
        check("t5_beats", out_log.size(), 2100);
        check("t5_frame_len_sat", o_frame_len, 11'd2047);
        src = {9'h15A};
        repeat (5) step(1'b1);
        check("t5_one_word_len", o_frame_len, 11'd1);

        // Reset mid-frame with the buffer full, then a fresh 2-word frame.
        clr_stats();
        src = {9'h071, 9'h072, 9'h073, 9'h074, 9'h075, 9'h176};
        repeat (4) step(1'b0);
        check("t6_pre_tvalid", o_tvalid, 1'b1);
        check("t6_pre_tdata", o_tdata, 8'h71);
        do_reset();
        clr_stats();
        src = {9'h021, 9'h122};
        repeat (6) step(1'b1);
        check("t6_frame_len", o_frame_len, 11'd2);
        check("t6_done_pulses", done_cnt, 1);
        exp_log = {9'h021, 9'h122};
        check_log("t6_seq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
